// File: rtl/dbg_status_monitor_pkg.sv
// Purpose: shared types, defaults and helpers for the GT bring-up debug status monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dbg_mon_pkg;

    localparam int DEF_N_CH        = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_N_CTRL      = 4;
    localparam int DEF_PULSE_LEN   = 16;

    // Per-channel control pulse FSM states; IDLE is the all-zero reset encoding.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        WAIT_LOW = 2'd2
    } ctrl_state_t;

    // Width of the pulse length counter; it only ever holds PULSE_LEN-1 down to 0,
    // but +1 keeps PULSE_LEN = 1 at a legal non-zero width.
    function automatic int pulse_cnt_w(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/dbg_status_monitor_if.sv
// Purpose: bundle of async status/VIO inputs and monitor outputs for dbg_status_monitor.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are free-running levels/pulses.
// Ports: master = VIO/transceiver side (drives raw levels, observes results),
//        slave  = monitor side (samples raw levels, drives results).
interface dbg_status_monitor_if
    import dbg_mon_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int N_CTRL = DEF_N_CTRL
);

    logic [N_CH-1:0]       status_in;
    logic                  clear_in;
    logic [N_CTRL-1:0]     ctrl_req_in;
    logic [N_CH-1:0]       status_sync_out;
    logic [N_CH-1:0]       sticky_low_out;
    logic [N_CH*CNT_W-1:0] trans_cnt_out;
    logic [N_CTRL-1:0]     ctrl_pulse_out;
    logic [N_CTRL-1:0]     ctrl_busy_out;

    modport master (
        output status_in, clear_in, ctrl_req_in,
        input  status_sync_out, sticky_low_out, trans_cnt_out, ctrl_pulse_out, ctrl_busy_out
    );

    modport slave (
        input  status_in, clear_in, ctrl_req_in,
        output status_sync_out, sticky_low_out, trans_cnt_out, ctrl_pulse_out, ctrl_busy_out
    );

endinterface

// File: rtl/dbg_status_monitor_pulse_fsm.sv
// Purpose: one control channel; turns a synchronised request level into a fixed PULSE_LEN pulse.
// Latency: req_sync rising edge to pulse high = 1 cycle; pulse high for exactly PULSE_LEN cycles.
// Backpressure: none; request edges seen outside IDLE are ignored (no extend, no restart).
// Ports: clk_in, rst_n (async active-low), req_sync in; pulse, busy out (both registered).
module dbg_pulse_fsm
    import dbg_mon_pkg::*;
#(
    parameter int PULSE_LEN = DEF_PULSE_LEN
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic req_sync,
    output logic pulse,
    output logic busy
);

    localparam int             CW   = pulse_cnt_w(PULSE_LEN);
    localparam logic [CW-1:0]  LOAD = CW'(PULSE_LEN - 1);

    ctrl_state_t   state;
    logic [CW-1:0] len_cnt;
    logic          req_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            len_cnt <= '0;
            req_q   <= 1'b0;
            pulse   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            // req_q tracks the request in every state, so a level that stayed
            // high across PULSE/WAIT_LOW never looks like a fresh edge in IDLE.
            req_q <= req_sync;
            case (state)
                IDLE: begin
                    if (req_sync && !req_q) begin
                        state   <= PULSE;
                        len_cnt <= LOAD;
                        pulse   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                PULSE: begin
                    if (len_cnt == '0) begin
                        pulse <= 1'b0;
                        if (req_sync) begin
                            state <= WAIT_LOW;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        len_cnt <= len_cnt - CW'(1);
                    end
                end
                WAIT_LOW: begin
                    if (!req_sync) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    pulse <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dbg_status_monitor.sv
// Purpose: GT bring-up monitor: synchronised status, sticky "dropped" latch, transition counters, VIO pulses.
// Latency: async in -> status_sync_out SYNC_STAGES cycles; sticky/count/clear/pulse +1 cycle after that.
// Backpressure: none; counters saturate, request edges during a pulse are ignored.
// Ports: clk_in, rst_n (async active-low), mon (dbg_status_monitor_if.slave).
// Build option: define DBG_MON_CNT_EN to build the transition counters; otherwise trans_cnt_out is 0.
module dbg_status_monitor
    import dbg_mon_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int N_CTRL      = DEF_N_CTRL,
    parameter int PULSE_LEN   = DEF_PULSE_LEN
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    dbg_status_monitor_if.slave  mon
);

    localparam int CNT_BITS = N_CH * CNT_W;

    logic [N_CH-1:0] st_s;   // synchronised status
    logic [N_CH-1:0] st_q;   // previous synchronised status
    logic [N_CH-1:0] fall;
    logic            clr_s;
    logic            clr_q;
    logic            clear_pulse;

    // ---------------- status synchronisers ----------------
    for (genvar i = 0; i < N_CH; i++) begin : g_st_sync
        (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] chain;
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) chain <= '0;
            else        chain <= {chain[SYNC_STAGES-2:0], mon.status_in[i]};
        end
        assign st_s[i] = chain[SYNC_STAGES-1];
    end

    // ---------------- clear synchroniser + edge ----------------
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] clr_chain;
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) clr_chain <= '0;
        else        clr_chain <= {clr_chain[SYNC_STAGES-2:0], mon.clear_in};
    end
    assign clr_s = clr_chain[SYNC_STAGES-1];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= '0;
            clr_q <= 1'b0;
        end else begin
            st_q  <= st_s;
            clr_q <= clr_s;
        end
    end

    assign clear_pulse         = clr_s & ~clr_q;
    assign fall                = ~st_s & st_q;
    assign mon.status_sync_out = st_s;

    // ---------------- armed / sticky ----------------
    for (genvar i = 0; i < N_CH; i++) begin : g_sticky
        (* DONT_TOUCH = "TRUE" *) logic armed;
        (* DONT_TOUCH = "TRUE" *) logic sticky;
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                armed  <= 1'b0;
                sticky <= 1'b0;
            end else begin
                // Clear re-arms from the present level so a channel that is
                // currently up can still be caught dropping afterwards.
                if (clear_pulse)  armed <= st_s[i];
                else if (st_s[i]) armed <= 1'b1;
                // A fall coinciding with clear still latches, judged on the
                // pre-clear armed state.
                sticky <= (sticky & ~clear_pulse) | (fall[i] & armed);
            end
        end
        assign mon.sticky_low_out[i] = sticky;
    end

    // ---------------- transition counters ----------------
`ifdef DBG_MON_CNT_EN
    logic [N_CH-1:0] rise;
    assign rise = st_s & ~st_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_cnt
        (* DONT_TOUCH = "TRUE" *) logic [CNT_W-1:0] cnt;
        logic evt;
        assign evt = rise[i] | fall[i];
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (clear_pulse) begin
                // Event in the clear cycle is applied on top of the cleared value.
                cnt <= evt ? CNT_W'(1) : '0;
            end else if (evt && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
        assign mon.trans_cnt_out[i*CNT_W +: CNT_W] = cnt;
    end
`else
    assign mon.trans_cnt_out = {CNT_BITS{1'b0}};
`endif

    // ---------------- control pulse channels ----------------
    for (genvar j = 0; j < N_CTRL; j++) begin : g_ctrl
        (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] chain;
        logic pulse_w;
        logic busy_w;
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) chain <= '0;
            else        chain <= {chain[SYNC_STAGES-2:0], mon.ctrl_req_in[j]};
        end

        dbg_pulse_fsm #(
            .PULSE_LEN (PULSE_LEN)
        ) u_pulse_fsm (
            .clk_in   (clk_in),
            .rst_n    (rst_n),
            .req_sync (chain[SYNC_STAGES-1]),
            .pulse    (pulse_w),
            .busy     (busy_w)
        );

        assign mon.ctrl_pulse_out[j] = pulse_w;
        assign mon.ctrl_busy_out[j]  = busy_w;
    end

endmodule

// File: doc/dbg_status_monitor.md
# dbg_status_monitor

Parametrised debug status/control monitor for GT bring-up. It sits between the transceiver status/reset nets and the VIO core, all in the free-running clock domain. For N_CH asynchronous status bits it provides a configurable-depth synchroniser, a sticky "dropped" latch and a saturating transition counter. It also converts N_CTRL asynchronous VIO request levels into fixed-length, self-rearming pulses.

## Interface
- N_CH, 8: number of monitored status channels (1..32)
- SYNC_STAGES, 2: synchroniser flops per async input (min 2)
- CNT_W, 8: transition counter width per channel (2..16)
- N_CTRL, 4: number of control pulse channels (1..16)
- PULSE_LEN, 16: control pulse length in clk_in cycles (min 1)

- clk_in  in  1  free-running clock; all logic in this domain
- rst_n  in  1  reset, asynchronous assert, active-low; release is synchronous to clk_in upstream
- status_in  in  N_CH  asynchronous status levels (e.g. gtpowergood, reset_done, link_status)
- clear_in  in  1  asynchronous level from VIO; rising edge clears sticky bits and counters
- ctrl_req_in  in  N_CTRL  asynchronous request levels from VIO
- status_sync_out  out  N_CH  synchronised status
- sticky_low_out  out  N_CH  latched: channel fell after having been high
- trans_cnt_out  out  N_CH*CNT_W  per-channel rising+falling transition count; channel i at [i*CNT_W +: CNT_W]
- ctrl_pulse_out  out  N_CTRL  fixed-length active-high pulses
- ctrl_busy_out  out  N_CTRL  high from pulse start until the request drops

## Operation
- Every async input (status_in, clear_in, ctrl_req_in) passes through a SYNC_STAGES-deep flop chain. Each chain resets to 0.
- The synchronised previous value is held in one register per channel. rise = s & ~s_q; fall = ~s & s_q.
- armed[i] is set on synchronised high and cleared by clear. sticky_low_out[i] is set on fall while armed, and held until clear.
- Counter: +1 on rise or fall, saturating at 2^CNT_W-1. It never wraps.
- clear_pulse = rising edge of the synchronised clear_in. It resets the counters to 0, sticky to 0, and armed to the current synchronised status.
- Clear and event in the same cycle: the event wins after the clear. The counter loads 1. Sticky sets if armed was 1 before the clear.
- Control FSM, per channel, 3 states:
  - IDLE: on a req rising edge, go to PULSE and load the length counter with PULSE_LEN-1.
  - PULSE: pulse = 1. The counter decrements. At 0, go to WAIT_LOW if req is still high, else IDLE.
  - WAIT_LOW: waits for req = 0, then goes to IDLE.
- Req toggles during PULSE are ignored; the pulse is not extended or restarted. busy = state != IDLE.

## Timing
- Reset value of every output and internal register: 0. FSMs start in IDLE.
- Async input to status_sync_out: SYNC_STAGES cycles, ±1 cycle sampling uncertainty.
- status_sync_out edge to sticky/counter update: +1 cycle, registered.
- Synchronised clear edge to cleared outputs: +1 cycle.
- Synchronised req edge to ctrl_pulse_out high: +1 cycle. The pulse is high for exactly PULSE_LEN cycles.
- A status high after reset release counts as one rise, because the synchroniser resets to 0.
- rst_n asserted mid-pulse: the pulse drops immediately (asynchronous) and the FSM goes to IDLE. A req still high after release produces a new pulse only once its synchronised edge is seen as 0 then 1.

## Configuration
- DBG_MON_CNT_EN defined: transition counters are built as described.
- DBG_MON_CNT_EN undefined: counters and their logic are removed and trans_cnt_out is tied to 0. Sticky and control logic are unchanged, and the port list is identical.

## Structure
- dbg_mon_pkg holds:
  - the control FSM state typedef (IDLE, PULSE, WAIT_LOW)
  - a clog2-based function for the pulse counter width, $clog2(PULSE_LEN+1)
  - default parameter constants
- One sub-module: dbg_pulse_fsm, one control channel (req_sync in; pulse, busy out). It is instantiated N_CTRL times in a generate loop.
- Synchronisers, sticky and counters are inline generate loops and carry ASYNC_REG / DONT_TOUCH attributes.

## Test plan
- Reset, then status_in[0] held high: status_sync_out[0] = 1 after 2 cycles; trans_cnt ch0 = 1; sticky_low_out = 0.
- Ch3 toggled 300 times with CNT_W = 8: trans_cnt ch3 = 255 (saturated); sticky_low_out[3] = 1.
- clear_in rising edge issued in the same synchronised cycle as a ch1 fall on an armed channel: ch1 count = 1, sticky_low_out[1] = 1; all other channels 0.
- ctrl_req_in[2] held high for 100 cycles with PULSE_LEN = 16: exactly one 16-cycle pulse; busy high until the req drops.
- ctrl_req_in[0] toggled every 3 cycles during a pulse: a single 16-cycle pulse, no retrigger until the FSM returns to IDLE.
- rst_n asserted at cycle 5 of a pulse: ctrl_pulse_out = 0 and all counts = 0 immediately. Repeated with DBG_MON_CNT_EN undefined: trans_cnt_out stays 0 throughout.
